rvv_xrf_wb_arbiter: RTL
=======================

# rvv_xrf_wb_arbiter

- Merges the `NUM_RT_UOP` scalar-register write-back slots from the vector backend's retire stage onto the single core scalar write port (`async_rd_*`).
- Drains slots in retirement order: slot 0 first, then higher indices, and each cycle's group before the next cycle's.
- Sits between `rvv_backend` (`rt_xrf_*`) and the core's scalar regfile, replacing the current slot-0-only tie-off.
- Buffers up to `DEPTH` results so that multi-slot retire bursts are never lost.

## Interface
Parameters:
- `NUM_REQ`, default `` `NUM_RT_UOP`` (4): number of retire write-back slots.
- `DEPTH`, default 8: number of buffer entries; must satisfy `DEPTH >= NUM_REQ`.
- `RegDataT`, default `logic [31:0]`: scalar data type.
- `RegAddrT`, default `logic [4:0]`: scalar register index type.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `req_valid_i`  in  NUM_REQ  per-slot write-back valid.
- `req_data_i`  in  NUM_REQ×RT2XRF_t  per-slot `{rt_index, rt_data}`.
- `req_ready_o`  out  NUM_REQ  per-slot accept; all bits always equal.
- `wb_valid_o`  out  1  scalar write valid.
- `wb_addr_o`  out  5  destination x-register.
- `wb_data_o`  out  32  write data.
- `wb_ready_i`  in  1  core accepts the write.
- `idle_o`  out  1  buffer empty.
- `occupancy_o`  out  $clog2(DEPTH+1)  current entry count.

## Operation
- Ready:
  - `req_ready_o = {NUM_REQ{(DEPTH - count) >= NUM_REQ}}`, computed from registered `count` only.
  - There is no combinational path from `req_valid_i` or `wb_ready_i` to `req_ready_o`.
- Accept:
  - Slot `i` transfers when `req_valid_i[i] && req_ready_o[i]`.
  - Valid slots need not be contiguous. For example, valid=4'b1010 pushes slot 1 then slot 3.
- Push order:
  - Accepted slots whose `rt_index != 0` are written in ascending index order into consecutive entries starting at `wr_ptr`.
  - Slots with `rt_index == 0` (x0) are accepted and discarded; they consume no entry.
- Pop:
  - `wb_valid_o = (count != 0)`.
  - `wb_addr_o` and `wb_data_o` come from the entry at `rd_ptr` and are driven by flops/RAM read only.
  - The head pops when `wb_valid_o && wb_ready_i`.
  - While `wb_valid_o` is high and `wb_ready_i` is low, `wb_addr_o` and `wb_data_o` hold stable.
- Pointers and count:
  - `wr_ptr` and `rd_ptr` wrap modulo `DEPTH`; `DEPTH` need not be a power of two, so wrap is explicit compare-and-reset.
  - `count_next = count + pushes - pop`.
  - Push and pop in the same cycle are both honoured.
  - `count` never exceeds `DEPTH`, guaranteed by the ready rule.
- State: per-entry storage plus `wr_ptr`, `rd_ptr`, `count`. There is no FSM beyond empty/non-empty/almost-full, which is implied by `count`.
- `idle_o = (count == 0)`. The wrapper ANDs it into `rvv_idle`.
- Reset:
  - Synchronous `rst` clears `wr_ptr`, `rd_ptr` and `count`.
  - Buffered entries are dropped, including when reset is asserted mid-burst.
  - Entry storage is not reset.

## Timing
- Values after reset:
  - `wb_valid_o=0`, `idle_o=1`, `occupancy_o=0`, `req_ready_o` all 1.
  - `wb_addr_o` and `wb_data_o` are don't-care while `wb_valid_o=0`.
- Latency: a request accepted in cycle T appears on `wb_*` at T+1 at the earliest, if the buffer was empty. It never appears in the same cycle.
- Throughput: one write-back per cycle out; up to `NUM_REQ` in per cycle.
- Backpressure:
  - When `count > DEPTH-NUM_REQ`, all `req_ready_o` drop low in the next cycle.
  - They rise one cycle after enough pops.
- Reset that is asserted while `wb_ready_i=1` causes no pop in that cycle.

## Structure
- `RT2XRF_t` and `` `NUM_RT_UOP`` stay in the shared backend package.
- Add `RVV_XRF_WB_DEPTH` as a package localparam used by the wrapper.
- One natural sub-module, `rvv_mpush_fifo`, provides the multi-push single-pop circular buffer:
  - Inputs: push-valid vector, ordered data vector, pop.
  - Outputs: head, count.
  - It is reusable for the vxsat/CSR write-back paths.
- The top level holds:
  - the x0 filter;
  - the prefix-count compaction, where `pos[i] = popcount(push_mask[i-1:0])`;
  - the ready logic.

## Test plan
- Single request: slot0 `{x5, 0xDEADBEEF}` with `wb_ready_i=1` → `wb_valid_o` rises 1 cycle later with x5/0xDEADBEEF for exactly 1 cycle; `idle_o` returns to 1.
- Burst ordering: all 4 slots valid `{x1,1},{x2,2},{x3,3},{x4,4}` in one cycle → outputs x1..x4 on 4 consecutive cycles; sparse mask 4'b1010 → slot1 then slot3.
- x0 discard: slots `{x0,7},{x9,9}` → only x9 emitted; `occupancy_o` peaks at 1.
- Full/backpressure:
  - Setup: `DEPTH=8`, `wb_ready_i=0`, two 4-slot bursts.
  - Expected: `occupancy_o=8` and `req_ready_o=0` hold while stalled; head data stays stable.
  - Release `wb_ready_i`: ready returns once `occupancy_o <= 4`; all 8 drain in order across the pointer wrap.
- Simultaneous push/pop: occupancy 3, push 2, pop 1 in the same cycle → occupancy 4; order preserved.
- Mid-operation reset: occupancy 5, assert `rst` for 1 cycle → next cycle `wb_valid_o=0`, `occupancy_o=0`, `req_ready_o` all 1; no stale entry is emitted afterwards.

Source files
------------

// File: rtl/rvv_xrf_wb_arbiter_pkg.sv
// rtl/rvv_xrf_wb_arbiter_pkg.sv - shared types and sizing for the scalar write-back arbiter
package rvv_xrf_wb_arbiter_pkg;

    localparam int NUM_RT_UOP       = 4;
    localparam int RVV_XRF_WB_DEPTH = 8;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

    typedef struct packed {
        reg_addr_t rt_index;
        reg_data_t rt_data;
    } RT2XRF_t;

    // Circular-buffer index advance; depth need not be a power of two, off never exceeds depth.
    function automatic int unsigned wrap_add(int unsigned base, int unsigned off, int unsigned depth);
        int unsigned sum;
        sum = base + off;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

endpackage

// File: rtl/rvv_xrf_wb_arbiter_if.sv
// rtl/rvv_xrf_wb_arbiter_if.sv - retire-slot and scalar write-port bundle
interface rvv_xrf_wb_arbiter_if
    import rvv_xrf_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_RT_UOP,
    parameter int DEPTH   = RVV_XRF_WB_DEPTH
) ();

    logic [NUM_REQ-1:0]            req_valid_i;
    RT2XRF_t [NUM_REQ-1:0]         req_data_i;
    logic [NUM_REQ-1:0]            req_ready_o;
    logic                          wb_valid_o;
    reg_addr_t                     wb_addr_o;
    reg_data_t                     wb_data_o;
    logic                          wb_ready_i;
    logic                          idle_o;
    logic [$clog2(DEPTH+1)-1:0]    occupancy_o;

    modport slave (
        input  req_valid_i, req_data_i, wb_ready_i,
        output req_ready_o, wb_valid_o, wb_addr_o, wb_data_o, idle_o, occupancy_o
    );

    modport master (
        output req_valid_i, req_data_i, wb_ready_i,
        input  req_ready_o, wb_valid_o, wb_addr_o, wb_data_o, idle_o, occupancy_o
    );

endinterface

// File: rtl/rvv_mpush_fifo.sv
// rtl/rvv_mpush_fifo.sv - multi-push single-pop circular buffer
// Push lanes must be packed from lane 0 upward; lane k lands at wr_ptr+k.
module rvv_mpush_fifo
    import rvv_xrf_wb_arbiter_pkg::*;
#(
    parameter int NUM_PUSH = 4,
    parameter int DEPTH    = 8,
    parameter int W        = 37
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PUSH-1:0]            push_valid_i,
    input  logic [NUM_PUSH-1:0][W-1:0]     push_data_i,
    input  logic                           pop_i,
    output logic [W-1:0]                   head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] n_push;
    logic [PW-1:0] slot_idx [NUM_PUSH];
    logic          pop_ok;

    assign pop_ok = pop_i && (count_q != '0);

    always_comb begin
        n_push = '0;
        for (int k = 0; k < NUM_PUSH; k++) begin
            slot_idx[k] = PW'(wrap_add(32'(wr_ptr_q), k, DEPTH));
            n_push      = n_push + CW'(push_valid_i[k]);
        end
        wr_ptr_d = PW'(wrap_add(32'(wr_ptr_q), 32'(n_push), DEPTH));
        rd_ptr_d = pop_ok ? PW'(wrap_add(32'(rd_ptr_q), 1, DEPTH)) : rd_ptr_q;
        count_d  = count_q + n_push - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately unreset; stale contents are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PUSH; k++) begin
            if (push_valid_i[k]) begin
                mem_q[slot_idx[k]] <= push_data_i[k];
            end
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/rvv_xrf_wb_arbiter.sv
// rtl/rvv_xrf_wb_arbiter.sv - merges retire write-back slots onto the single scalar write port
module rvv_xrf_wb_arbiter
    import rvv_xrf_wb_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_RT_UOP,
    parameter int DEPTH   = RVV_XRF_WB_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    rvv_xrf_wb_arbiter_if.slave  bus
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int EW = $bits(RT2XRF_t);

    logic                        req_ready;
    logic                        wb_valid;
    logic                        pop;
    logic [NUM_REQ-1:0]          kept;
    logic [NUM_REQ-1:0]          push_valid;
    logic [NUM_REQ-1:0][EW-1:0]  push_data;
    logic [IW-1:0]               pos;
    logic [EW-1:0]               head;
    logic [CW-1:0]               count;
    RT2XRF_t                     head_entry;

    // Ready looks only at registered count, so a full burst always fits.
    assign req_ready = (int'(count) <= DEPTH - NUM_REQ);
    assign wb_valid  = (count != '0);
    assign pop       = wb_valid && bus.wb_ready_i;

    // x0 writes are swallowed; survivors are packed so lane pos[i] = popcount(kept[i-1:0]).
    always_comb begin
        kept       = '0;
        push_valid = '0;
        push_data  = '0;
        pos        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            kept[i] = bus.req_valid_i[i] && req_ready && (bus.req_data_i[i].rt_index != '0);
            if (kept[i]) begin
                push_valid[pos] = 1'b1;
                push_data[pos]  = bus.req_data_i[i];
                pos             = pos + IW'(1);
            end
        end
    end

    rvv_mpush_fifo #(
        .NUM_PUSH (NUM_REQ),
        .DEPTH    (DEPTH),
        .W        (EW)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_valid_i (push_valid),
        .push_data_i  (push_data),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    assign head_entry      = RT2XRF_t'(head);
    assign bus.req_ready_o = {NUM_REQ{req_ready}};
    assign bus.wb_valid_o  = wb_valid;
    assign bus.wb_addr_o   = head_entry.rt_index;
    assign bus.wb_data_o   = head_entry.rt_data;
    assign bus.idle_o      = ~wb_valid;
    assign bus.occupancy_o = count;

endmodule
